// File: rtl/cc_pkg.sv
// Shared cache-controller definitions: AXI line-fill constants, miss FSM
// states and the address field layout the fill unit decodes.
package cc_pkg;

  localparam logic [3:0] CC_ARLEN_LINE   = 4'd7;
  localparam logic [2:0] CC_ARSIZE_8B    = 3'd3;
  localparam logic [1:0] CC_ARBURST_WRAP = 2'b10;

  // Line address layout: [31:15] tag, [14:6] set index, [5:3] dword, [2:0] byte
  localparam int CC_BYTE_OFF_W = 3;
  localparam int CC_WORD_OFF_W = 3;
  localparam int CC_INDEX_W    = 9;
  localparam int CC_TAG_W      = 17;

  typedef enum logic {
    CC_MISS_IDLE,
    CC_MISS_AR_REQ
  } cc_miss_state_e;

  function automatic logic [31:0] cc_dw_align(input logic [31:0] addr);
    return addr & ~((32'd1 << CC_BYTE_OFF_W) - 32'd1);
  endfunction

endpackage

// File: rtl/cc_miss_addr_fifo.sv
// Show-ahead synchronous FIFO; pointers carry an extra wrap bit so full and
// empty are distinguishable. Storage is intentionally left unreset.
module cc_miss_addr_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en_i,
  input  logic [WIDTH-1:0]           wdata_i,
  input  logic                       rd_en_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0]      wptr_q;
  logic [AW:0]      rptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             push;
  logic             pop;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign count_o = wptr_q - rptr_q;
  assign rdata_o = mem_q[rptr_q[AW-1:0]];

  // Pops of an empty FIFO are dropped here so callers need not qualify rd_en_i
  assign push = wr_en_i & ~full_o;
  assign pop  = rd_en_i & ~empty_o;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + PTR_ONE;
      if (pop)  rptr_q <= rptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/cc_miss_req_unit.sv
// Miss front end: one outstanding AR line-fill request at a time, with every
// issued line address queued for the downstream fill unit.
module cc_miss_req_unit
  import cc_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          miss_i,
  input  logic [31:0]                   miss_addr_i,
  output logic                          miss_ready_o,
  output logic                          mem_arvalid_o,
  input  logic                          mem_arready_i,
  output logic [31:0]                   mem_araddr_o,
  output logic [3:0]                    mem_arlen_o,
  output logic [2:0]                    mem_arsize_o,
  output logic [1:0]                    mem_arburst_o,
  output logic                          miss_addr_fifo_empty_o,
  output logic [31:0]                   miss_addr_fifo_rdata_o,
  input  logic                          miss_addr_fifo_rden_i,
  output logic [$clog2(FIFO_DEPTH):0]   miss_pending_o
);

  cc_miss_state_e state_q;
  logic [31:0]    araddr_q;
  logic           arvalid_q;
  logic           fifo_full;
  logic           accept;
  logic [31:0]    miss_line_addr;

  assign miss_line_addr = cc_dw_align(miss_addr_i);

  // Ready comes only from registered state and registered full, so a pop
  // in the same cycle cannot open the door early.
  assign miss_ready_o = (state_q == CC_MISS_IDLE) & ~fifo_full;
  assign accept       = miss_i & miss_ready_o;

  assign mem_arvalid_o = arvalid_q;
  assign mem_araddr_o  = araddr_q;
  assign mem_arlen_o   = CC_ARLEN_LINE;
  assign mem_arsize_o  = CC_ARSIZE_8B;
  assign mem_arburst_o = CC_ARBURST_WRAP;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= CC_MISS_IDLE;
      araddr_q  <= '0;
      arvalid_q <= 1'b0;
    end else begin
      case (state_q)
        CC_MISS_IDLE: begin
          if (accept) begin
            araddr_q  <= miss_line_addr;
            arvalid_q <= 1'b1;
            state_q   <= CC_MISS_AR_REQ;
          end
        end
        CC_MISS_AR_REQ: begin
          if (mem_arready_i) begin
            arvalid_q <= 1'b0;
            state_q   <= CC_MISS_IDLE;
          end
        end
        default: begin
          arvalid_q <= 1'b0;
          state_q   <= CC_MISS_IDLE;
        end
      endcase
    end
  end

  cc_miss_addr_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_miss_addr_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en_i (accept),
    .wdata_i (miss_line_addr),
    .rd_en_i (miss_addr_fifo_rden_i),
    .rdata_o (miss_addr_fifo_rdata_o),
    .full_o  (fifo_full),
    .empty_o (miss_addr_fifo_empty_o),
    .count_o (miss_pending_o)
  );

endmodule

// File: doc/cc_miss_req_unit.md
# cc_miss_req_unit

Cache-controller miss front end: accepts one miss address at a time from the tag-compare stage, issues a single 8-beat critical-word-first AXI read burst on the AR channel, and records the address in an internal miss-address FIFO. The data fill unit downstream pops that FIFO as the first R beat of each burst arrives and uses the stored address to place the beats and write the tag/data SRAM.

## Interface
- FIFO_DEPTH, 4: miss-address FIFO entries; power of two, ≥2
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- miss_i  in  1  miss request from tag compare
- miss_addr_i  in  32  byte address of missing access
- miss_ready_o  out  1  request accepted when miss_i & miss_ready_o
- mem_arvalid_o  out  1  AXI AR valid
- mem_arready_i  in  1  AXI AR ready
- mem_araddr_o  out  32  AXI AR address, {miss_addr[31:3],3'b000}
- mem_arlen_o  out  4  constant 4'd7 (8 beats)
- mem_arsize_o  out  3  constant 3'd3 (8 bytes/beat)
- mem_arburst_o  out  2  constant 2'b10 (WRAP)
- miss_addr_fifo_empty_o  out  1  FIFO empty
- miss_addr_fifo_rdata_o  out  32  head entry (show-ahead)
- miss_addr_fifo_rden_i  in  1  pop head
- miss_pending_o  out  3..log2(FIFO_DEPTH)+1  current FIFO occupancy

## Operation
- FSM states: IDLE, AR_REQ.
- IDLE: miss_ready_o = ~fifo_full. On accept: latch {miss_addr_i[31:3],3'b000} into AR address register, push same aligned address into FIFO, go AR_REQ.
- AR_REQ: mem_arvalid_o = 1, address held stable; on mem_arready_i go IDLE. miss_ready_o = 0.
- WRAP burst with 8-byte-aligned start address returns requested doubleword first; FIFO entry bits [5:3] give the fill unit its rotation offset, [14:6] the set index, [31:15] the tag.
- FIFO: 32-bit wide, FIFO_DEPTH entries, read/write pointers with one extra wrap bit; full = pointers equal except wrap bit; empty = pointers equal. Occupancy = wptr − rptr modulo 2·FIFO_DEPTH.
- Pop when empty: ignored, pointers unchanged. Push when full: impossible (ready low).
- Simultaneous push and pop: both take effect; occupancy unchanged.
- miss_ready_o uses registered full only; a same-cycle pop does not raise it (no combinational path rden_i → miss_ready_o).
- Constant AR fields driven at all times, including reset.

## Timing
- Reset values: state IDLE, mem_arvalid_o 0, mem_araddr_o 0, FIFO empty (miss_addr_fifo_empty_o 1, miss_pending_o 0), miss_ready_o 1, miss_addr_fifo_rdata_o don't-care (storage not reset).
- Accept in cycle N → mem_arvalid_o high from N+1; FIFO empty_o low from N+1.
- arready in cycle M (M ≥ N+1) → arvalid low and miss_ready_o high (if not full) in M+1. Minimum 2 cycles per miss; arready already high at N+1 gives handshake in N+1.
- Pop in cycle P → head advances, occupancy decrements at P+1.
- Reset asserted mid-burst: all state cleared immediately (async), arvalid drops without handshake; memory side is reset together.
- Outputs are registered except miss_ready_o (state & full, both registered) and rdata (registered storage indexed by registered pointer).

## Structure
- Package cc_pkg: CC_ARLEN_LINE = 4'd7, CC_ARSIZE_8B = 3'd3, CC_ARBURST_WRAP = 2'b10, miss FSM state enum, line/offset field widths shared with the fill unit.
- Sub-module cc_miss_addr_fifo: generic synchronous FIFO (parameters WIDTH, DEPTH), show-ahead read, full/empty/count outputs, async active-high reset on pointers only.
- Top holds FSM, AR address register, and glue.

## Test plan
- Reset then single miss 0x0000_1238, arready tied 1 → arvalid one cycle, araddr 0x0000_1238 (already aligned), arlen 7, arsize 3, arburst 2; FIFO head 0x0000_1238, pending 1.
- Miss 0xABCD_0E7F with arready held low 5 cycles → arvalid and araddr 0xABCD_0E78 stable 5 cycles, miss_ready_o 0 throughout, handshake on cycle 6.
- Four misses, no pops, FIFO_DEPTH 4 → pending 4, miss_ready_o stays 0 with miss_i high; one pop → miss_ready_o 1 next cycle, fifth miss accepted.
- Pop issued in same cycle as accept with pending 2 → pending remains 2, head advances to second entry.
- Pop with FIFO empty → no change, empty_o stays 1, pending 0.
- Reset pulsed while arvalid high with 3 entries queued → arvalid 0, empty 1, pending 0 immediately; subsequent miss handled normally.
